// File: rtl/mips_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and
// word/address constants.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN,
        LDR_DATA,
        LDR_WRITE,
        LDR_DONE,
        LDR_ERR
    } ldr_state_t;

    // Bytes per instruction word, and byte-address increment per word.
    localparam int LDR_WORD_BYTES = 4;
    localparam int LDR_ADDR_STEP  = 4;

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th idle cycle is being spent.
module loader_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Fires combinationally so the FSM can leave on the same edge the
    // counter would otherwise step past TIMEOUT-1.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    // Idle-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, packs
// big-endian 32-bit words and writes them to instruction memory at
// consecutive word addresses while holding the CPU.
module prog_loader
    import mips_loader_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int TIMEOUT   = 1000
) (
    input  logic        clk_LOADER,
    input  logic        rst_LOADER,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    ldr_state_t state;
    logic [7:0] words_left;
    logic [1:0] byte_idx;
    logic       loading;
    logic       xfer;
    logic       expired;

    // Handshake and status outputs are pure decodes of the state register,
    // so byte_ready never depends on byte_valid.
    assign loading    = (state == LDR_LEN) || (state == LDR_DATA);
    assign byte_ready = loading;
    assign xfer       = byte_valid && loading;
    assign wr_en      = (state == LDR_WRITE);
    assign cpu_hold   = (state != LDR_DONE);
    assign done       = (state == LDR_DONE);
    assign error      = (state == LDR_ERR);

    // Held clear outside LEN/DATA, which also covers the entry clear: LEN is
    // entered from a non-loading state, DATA from WRITE or via an accepted
    // length byte.
    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk_LOADER),
        .rst     (rst_LOADER),
        .clear   (xfer || !loading),
        .enable  (loading && !xfer),
        .expired (expired)
    );

    // Loader FSM with its datapath registers (address, word shifter, counts).
    always_ff @(posedge clk_LOADER or posedge rst_LOADER) begin
        if (rst_LOADER) begin
            state      <= LDR_IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            words_left <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                LDR_IDLE, LDR_DONE, LDR_ERR: begin
                    if (start) begin
                        state   <= LDR_LEN;
                        wr_addr <= '0;
                    end
                end
                LDR_LEN: begin
                    if (xfer) begin
                        if (byte_in == 8'd0 || {1'b0, byte_in} > MAX_N) begin
                            state <= LDR_ERR;
                        end else begin
                            words_left <= byte_in;
                            byte_idx   <= '0;
                            state      <= LDR_DATA;
                        end
                    end else if (expired) begin
                        state <= LDR_ERR;
                    end
                end
                LDR_DATA: begin
                    if (xfer) begin
                        wr_data  <= {wr_data[23:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'(LDR_WORD_BYTES - 1))
                            state <= LDR_WRITE;
                    end else if (expired) begin
                        state <= LDR_ERR;
                    end
                end
                LDR_WRITE: begin
                    wr_addr    <= wr_addr + 8'(LDR_ADDR_STEP);
                    words_left <= words_left - 8'd1;
                    state      <= (words_left == 8'd1) ? LDR_DONE : LDR_DATA;
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

endmodule
